// File: rtl/mix_in_unit_buffered.sv
// rtl/mix_in_unit_buffered.sv - MIX input unit: UART bytes to MIX words, FIFO-buffered block stores
module mix_in_unit_buffered #(
    parameter int BYTE_W         = 6,
    parameter int BYTES_PER_WORD = 5,
    parameter int BLOCK_WORDS    = 14,
    parameter int ADDR_W         = 12,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                addr_in,
    output logic                             busy,
    output logic                             stop,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             store_req,
    output logic [ADDR_W-1:0]                store_addr,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] store_data,
    input  logic                             store_ack,
    output logic                             overrun,
    output logic                             bad_char,
    input  logic                             clear_err
);
    localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BC_W   = $clog2(BYTES_PER_WORD + 1);
    localparam int WC_W   = $clog2(BLOCK_WORDS + 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [7:0]        letter;
    logic [7:0]        code8;
    logic              keep;
    logic              illegal;
    logic [BYTE_W-1:0] byte_code;

    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] next_word;
    logic [BC_W-1:0]   byte_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              pending;
    logic [ADDR_W-1:0] pend_addr;

    logic accept, word_done, fifo_full, fifo_empty, push, pop, done, flush, stop_set;

    // ASCII to MIX code; letters compared with bit 5 cleared so case is ignored
    always_comb begin
        letter  = rx_data & 8'hDF;
        code8   = 8'd0;
        keep    = 1'b1;
        illegal = 1'b0;
        if (rx_data == 8'h0D || rx_data == 8'h0A) begin
            keep = 1'b0;
        end else if (rx_data == 8'h20) begin
            code8 = 8'd0;
        end else if (letter >= 8'h41 && letter <= 8'h49) begin
            code8 = letter - 8'h40;
        end else if (letter >= 8'h4A && letter <= 8'h52) begin
            code8 = letter - 8'h3F;
        end else if (letter >= 8'h53 && letter <= 8'h5A) begin
            code8 = letter - 8'h3D;
        end else if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            code8 = rx_data - 8'h12;
        end else begin
            case (rx_data)
                8'h2E:   code8 = 8'd40;
                8'h2C:   code8 = 8'd41;
                8'h28:   code8 = 8'd42;
                8'h29:   code8 = 8'd43;
                8'h2B:   code8 = 8'd44;
                8'h2D:   code8 = 8'd45;
                8'h2A:   code8 = 8'd46;
                8'h2F:   code8 = 8'd47;
                8'h3D:   code8 = 8'd48;
                8'h24:   code8 = 8'd49;
                8'h3C:   code8 = 8'd50;
                8'h3E:   code8 = 8'd51;
                8'h40:   code8 = 8'd52;
                8'h3B:   code8 = 8'd53;
                8'h3A:   code8 = 8'd54;
                8'h27:   code8 = 8'd55;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign byte_code  = BYTE_W'(code8[5:0]);
    assign next_word  = (asm_word << BYTE_W) | WORD_W'(byte_code);
    assign accept     = busy & rx_valid & keep;
    assign word_done  = accept && (byte_cnt == LAST_BYTE);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = word_done & ~fifo_full;
    assign store_req  = busy & ~fifo_empty;
    assign store_data = fifo_mem[rd_ptr];
    assign pop        = store_req & store_ack;
    assign done       = pop && (word_cnt == LAST_WORD);
    // A fresh block (from idle or right after an unqueued completion) or a plain completion discards buffered data
    assign flush      = (start & ~busy) | (done & ~pending);
    assign stop_set   = (start & ~busy) | (done & (pending | start));

    // Word FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= next_word;
        end
    end

    // Byte assembler and FIFO pointers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            asm_word <= '0;
            byte_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept) begin
                asm_word <= next_word;
                byte_cnt <= word_done ? '0 : byte_cnt + BC_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // Block sequencing: start, queued request, store address and word count
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            stop       <= 1'b0;
            pending    <= 1'b0;
            pend_addr  <= '0;
            store_addr <= '0;
            word_cnt   <= '0;
        end else begin
            stop <= stop_set & ~stop;
            if (done) begin
                word_cnt <= '0;
                if (pending) begin
                    store_addr <= pend_addr;
                    if (start) begin
                        pend_addr <= addr_in;
                    end else begin
                        pending <= 1'b0;
                    end
                end else if (start) begin
                    store_addr <= addr_in;
                end else begin
                    busy <= 1'b0;
                end
            end else begin
                if (pop) begin
                    store_addr <= store_addr + ADDR_W'(1);
                    word_cnt   <= word_cnt + WC_W'(1);
                end
                if (start) begin
                    if (!busy) begin
                        busy       <= 1'b1;
                        store_addr <= addr_in;
                        word_cnt   <= '0;
                    end else if (!pending) begin
                        pending   <= 1'b1;
                        pend_addr <= addr_in;
                    end
                end
            end
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            bad_char <= 1'b0;
        end else begin
            if (word_done && fifo_full) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (busy && rx_valid && illegal) begin
                bad_char <= 1'b1;
            end else if (clear_err) begin
                bad_char <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mix_in_unit_buffered.sv
// tb/tb_mix_in_unit_buffered.sv - self-checking bench for mix_in_unit_buffered
module tb_mix_in_unit_buffered;
    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] addr_in;
    logic        busy;
    logic        stop;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        store_req;
    logic [11:0] store_addr;
    logic [29:0] store_data;
    logic        store_ack;
    logic        overrun;
    logic        bad_char;
    logic        clear_err;

    int checks = 0;
    int errors = 0;
    int stop_cnt = 0;
    int dbl_stop = 0;
    logic prev_stop = 1'b0;
    int s0;

    typedef struct {
        logic [39:0] bytes;
        logic [29:0] word;
        logic        bad;
    } vec_t;
    vec_t vecs [7];

    mix_in_unit_buffered #(
        .BYTE_W(6), .BYTES_PER_WORD(5), .BLOCK_WORDS(2), .ADDR_W(12), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .addr_in(addr_in), .busy(busy), .stop(stop),
        .rx_data(rx_data), .rx_valid(rx_valid), .store_req(store_req), .store_addr(store_addr),
        .store_data(store_data), .store_ack(store_ack), .overrun(overrun), .bad_char(bad_char),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (stop) stop_cnt = stop_cnt + 1;
        if (stop && prev_stop) dbl_stop = dbl_stop + 1;
        prev_stop = stop;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; store_ack = 1'b0; clear_err = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] a);
        start = 1'b1; addr_in = a;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [39:0] w);
        for (int j = 0; j < 5; j++) send(w[39-8*j -: 8]);
    endtask

    task automatic ack;
        store_ack = 1'b1;
        tick;
        store_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"AB C1", 30'h10800DF, 1'b0};
        vecs[1] = '{"abc z", 30'h108301D, 1'b0};
        vecs[2] = '{"JRSI9", 30'h0B4D6267, 1'b0};
        vecs[3] = '{".,()+", 30'h28A6AAEC, 1'b0};
        vecs[4] = '{"-*/=$", 30'h2DBAFC31, 1'b0};
        vecs[5] = '{"<>@;:", 30'h32CF4D76, 1'b0};
        vecs[6] = '{{8'h27, 8'h7E, "Z0 "}, 30'h3701D780, 1'b1};

        addr_in = '0; rx_data = '0;
        do_reset;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stop", 32'(stop), 32'd0);
        check("rst_req", 32'(store_req), 32'd0);
        check("rst_addr", 32'(store_addr), 32'd0);
        check("rst_flags", 32'({overrun, bad_char}), 32'd0);

        // Translation table: one word per vector
        for (int i = 0; i < 7; i++) begin
            do_reset;
            do_start(12'(100 + i));
            check("vec_stop", 32'(stop), 32'd1);
            send_word(vecs[i].bytes);
            check("vec_req", 32'(store_req), 32'd1);
            check("vec_data", 32'(store_data), 32'(vecs[i].word));
            check("vec_addr", 32'(store_addr), 32'(100 + i));
            check("vec_bad", 32'(bad_char), 32'(vecs[i].bad));
        end

        // Encoding example: ack advances address
        do_reset;
        do_start(12'd100);
        check("enc_stop", 32'(stop), 32'd1);
        tick;
        check("enc_stop_low", 32'(stop), 32'd0);
        send_word("AB C1");
        ack;
        check("enc_addr_inc", 32'(store_addr), 32'd101);

        // Full block with CR/LF interleaved
        do_reset;
        s0 = stop_cnt;
        do_start(12'd100);
        foreach (vecs[k]) begin end
        begin
            logic [79:0] msg;
            msg = "HELLOWORLD";
            for (int j = 0; j < 10; j++) begin
                send(msg[79-8*j -: 8]);
                send(8'h0D);
                send(8'h0A);
            end
        end
        check("blk_addr0", 32'(store_addr), 32'd100);
        check("blk_data0", 32'(store_data), 32'h0814D350);
        ack;
        check("blk_addr1", 32'(store_addr), 32'd101);
        check("blk_data1", 32'(store_data), 32'h1A413344);
        check("blk_busy1", 32'(busy), 32'd1);
        ack;
        check("blk_busy_end", 32'(busy), 32'd0);
        check("blk_req_end", 32'(store_req), 32'd0);
        tick; tick;
        check("blk_stop_count", 32'(stop_cnt - s0), 32'd1);

        // Queued block
        do_reset;
        s0 = stop_cnt;
        do_start(12'd200);
        check("q_stop1", 32'(stop), 32'd1);
        tick;
        do_start(12'd300);
        check("q_nostop2", 32'(stop), 32'd0);
        check("q_busy", 32'(busy), 32'd1);
        send_word("AAAAA");
        send_word("BBBBB");
        check("q_addr200", 32'(store_addr), 32'd200);
        ack;
        check("q_addr201", 32'(store_addr), 32'd201);
        ack;
        check("q_stop_done", 32'(stop), 32'd1);
        check("q_addr300", 32'(store_addr), 32'd300);
        check("q_busy_done", 32'(busy), 32'd1);
        tick;
        check("q_stop_low", 32'(stop), 32'd0);
        send_word("CCCCC");
        check("q_req3", 32'(store_req), 32'd1);
        check("q_data3", 32'(store_data), 32'h030C30C3);
        check("q_stop_count", 32'(stop_cnt - s0), 32'd2);
        // Completion together with a new start and nothing queued
        ack;
        check("cs_addr301", 32'(store_addr), 32'd301);
        send_word("DDDDD");
        store_ack = 1'b1; start = 1'b1; addr_in = 12'd400;
        tick;
        store_ack = 1'b0; start = 1'b0;
        check("cs_busy", 32'(busy), 32'd1);
        check("cs_stop", 32'(stop), 32'd1);
        check("cs_addr400", 32'(store_addr), 32'd400);
        check("cs_req", 32'(store_req), 32'd0);

        // Overrun with a two-entry FIFO
        do_reset;
        do_start(12'd0);
        send_word("AAAAA");
        send_word("BBBBB");
        check("ovr_before", 32'(overrun), 32'd0);
        send_word("CCCCC");
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_head1", 32'(store_data), 32'h01041041);
        ack;
        check("ovr_head2", 32'(store_data), 32'h02082082);
        check("ovr_addr1", 32'(store_addr), 32'd1);
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);

        // Illegal byte with a same-cycle clear, then plain clear
        do_reset;
        do_start(12'd5);
        clear_err = 1'b1;
        send(8'h7E);
        clear_err = 1'b0;
        check("bad_wins", 32'(bad_char), 32'd1);
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        check("bad_clear", 32'(bad_char), 32'd0);

        // Bytes while idle are dropped
        do_reset;
        send_word("HELLO");
        check("idle_req", 32'(store_req), 32'd0);
        do_start(12'd10);
        send_word("AB C1");
        check("idle_data", 32'(store_data), 32'h010800DF);
        check("idle_addr", 32'(store_addr), 32'd10);

        // Reset mid-block
        do_reset;
        do_start(12'd20);
        send(8'h58); send(8'h59); send(8'h7E);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_stop", 32'(stop), 32'd0);
        check("mid_req", 32'(store_req), 32'd0);
        check("mid_addr", 32'(store_addr), 32'd0);
        check("mid_flags", 32'({overrun, bad_char}), 32'd0);
        do_start(12'd50);
        send_word("AB C1");
        check("mid_new_addr", 32'(store_addr), 32'd50);
        check("mid_new_data", 32'(store_data), 32'h010800DF);

        tick;
        check("no_double_stop", 32'(dbl_stop), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_in_unit_buffered.md
Name: mix_in_unit_buffered

Overview:
Parametrised MIX input-device controller. It takes received UART bytes, skips CR/LF, translates ASCII to MIX character codes and packs them into words, most significant byte first. Completed words go through a small word FIFO and are stored into CPU memory, one block of BLOCK_WORDS words per IN instruction. It holds one queued block request, so the CPU can issue a second IN while a block is still in progress. It adds overrun and illegal-character status flags.

Parameters:
BYTE_W, 6, bits per MIX byte
BYTES_PER_WORD, 5, MIX bytes per word (sign excluded)
BLOCK_WORDS, 14, words per block (IN transfer)
ADDR_W, 12, memory address width
FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  sync reset
start  in  1  CPU issues IN, 1-cycle pulse
addr_in  in  ADDR_W  block start address, sampled with start
busy  out  1  a block is in progress
stop  out  1  1-cycle pulse: CPU may resume
rx_data  in  8  received byte
rx_valid  in  1  1-cycle strobe, rx_data valid
store_req  out  1  word ready for memory write
store_addr  out  ADDR_W  write address
store_data  out  BYTES_PER_WORD*BYTE_W  word, first byte in MSBs
store_ack  in  1  memory accepted word this cycle
overrun  out  1  sticky: word lost because FIFO was full
bad_char  out  1  sticky: unmapped ASCII received
clear_err  in  1  clears sticky flags

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: busy, stop, store_req, overrun, bad_char, pending = 0; store_addr = 0. FIFO, byte counter, word counter and assembler are cleared. Reset mid-block aborts the block with no stop pulse.
- Translation (bit 5 ignored for letters, so lowercase equals uppercase):
  - space 0; A-I 1-9; J-R 11-19; S-Z 22-29; 0-9 30-39.
  - . , ( ) + - * / = $ < > @ ; : ' map to 40 to 55 in that order.
  - 0x0D and 0x0A are discarded without being counted.
  - Any other byte gives code 0, is counted, and sets bad_char.
- Assembly runs only while busy; bytes arriving while idle are dropped.
  - Each counted byte shifts into the assembler at the LSB end.
  - On byte BYTES_PER_WORD the completed word is pushed into the FIFO in the same cycle, and the counter returns to 0.
  - A word completed at cycle N appears at the FIFO head at N+1.
  - FIFO full on push: the word is dropped, overrun is set, and the word counter is not advanced.
- Store handshake:
  - store_req = busy & FIFO not empty. store_data is the FIFO head.
  - On store_req & store_ack: pop the FIFO, increment store_addr modulo 2^ADDR_W, increment the word counter.
  - FIFO push and pop may occur in the same cycle; occupancy is then unchanged.
- Block control, on start:
  - ~busy: busy <= 1, store_addr <= addr_in, counters and FIFO cleared, stop pulses the next cycle.
  - busy & ~pending: pending <= 1, pend_addr <= addr_in. No stop pulse; the CPU stays blocked.
  - busy & pending: start is ignored (protocol violation, no state change).
- Block completion is the ack of word BLOCK_WORDS:
  - pending = 1: store_addr <= pend_addr, word counter <= 0, pending <= 0, busy stays 1, stop pulses the next cycle. FIFO contents and the partial word carry into the new block.
  - pending = 0: busy <= 0; FIFO and assembler are flushed; no stop pulse.
- start in the same cycle as completion:
  - pending = 0: the new block starts at addr_in with busy held at 1, and stop pulses.
  - pending = 1: the queued block starts, addr_in becomes the new pending entry, and stop pulses.
- Sticky flags: a flag-set event outranks clear_err in the same cycle.
- stop never stays high for two consecutive cycles.

Test Plan:
- Encoding: reset; start with addr_in=100, then send 0x41 0x42 0x20 0x43 0x31 ("AB C1"). Expect stop at the cycle after start, store_req with store_data=0x10800DF and store_addr=100; ack -> store_addr=101.
- Full block: BLOCK_WORDS=2, 10 bytes with interleaved 0x0D 0x0A, then ack each word. Expect addresses 100 and 101; busy falls the cycle after the 2nd ack; no second stop pulse.
- Queued block: start(200), then start(300) while busy. Expect no stop at the 2nd start; after word BLOCK_WORDS at 200+BLOCK_WORDS-1 is acked, stop pulses once and the next store_addr=300.
- Overrun: FIFO_DEPTH=2, hold store_ack=0 and send 3 words. Expect overrun=1 and the FIFO holding words 1 and 2; clear_err -> overrun=0.
- Illegal and idle input: send 0x7E while busy -> bad_char=1 and a 0 code in that byte position. Send bytes while idle -> no store_req.
- Reset mid-block after 3 bytes: all outputs 0; a later start(50) begins a clean word at address 50.
